// File: rtl/coffer_pkg.sv
// Shared definitions for the coffer lock: controller state encoding, digit width
// and the seven-segment glyph table used by the display drivers.
package coffer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ENTRY     = 3'd1,
        CHECK     = 3'd2,
        OPEN      = 3'd3,
        SET_ENTRY = 3'd4,
        LOCKOUT   = 3'd5
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active high; hex glyphs 0-F.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [6:0] seg7_decode(input logic [DIGIT_W-1:0] d);
        case (d)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/coffer_lock_timer.sv
// Loadable down-counter for the lockout period; load wins over decrement.
// Zero flag is decoded from the count register; it holds at zero rather than wrapping.
module coffer_lock_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/coffer_seq_ctrl.sv
// Code-entry sequencer for the coffer lock: collects digits, checks, counts failures, locks out.
// Open/error indication 2 cycles after the last enter pulse; inputs are pulses, no backpressure.
module coffer_seq_ctrl
    import coffer_pkg::*;
#(
    parameter int                         DIGITS         = 4,
    parameter int                         ALLOWED        = 4,
    parameter int                         LOCKOUT_CYCLES = 50_000_000,
    parameter logic [DIGIT_W*DIGITS-1:0]  DEFAULT_PSWD   = 16'h0007
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               enter,
    input  logic               cancel,
    input  logic               confirm,
    input  logic               close,
    output logic               green_n,
    output logic               red_n,
    output logic               locked,
    output logic [2:0]         tries_left,
    output logic [2:0]         digit_idx,
    output logic [2:0]         state_o
);

    localparam int         CODE_W    = DIGIT_W * DIGITS;
    localparam int         TW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [2:0] LAST_IDX  = 3'(DIGITS - 1);
    localparam logic [2:0] ALLOWED_3 = 3'(ALLOWED);

    state_t                          state, state_nxt;
    logic [DIGITS-1:0][DIGIT_W-1:0]  entry_buf, buf_nxt, buf_wr;
    logic [CODE_W-1:0]               pswd, pswd_nxt;
    logic [2:0]                      idx, idx_nxt;
    logic [2:0]                      fail_cnt, fail_nxt;
    logic                            err_flag, err_nxt;
    logic                            tmr_load, tmr_dec, tmr_zero;

    coffer_lock_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .value (TW'(LOCKOUT_CYCLES - 1)),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            entry_buf <= '0;
            pswd      <= DEFAULT_PSWD;
            idx       <= '0;
            fail_cnt  <= '0;
            err_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            entry_buf <= buf_nxt;
            pswd      <= pswd_nxt;
            idx       <= idx_nxt;
            fail_cnt  <= fail_nxt;
            err_flag  <= err_nxt;
        end
    end

    // First-entered digit lands in the most significant nibble.
    always_comb begin
        buf_wr = entry_buf;
        for (int j = 0; j < DIGITS; j++) begin
            if ((LAST_IDX - idx) == 3'(j)) begin
                buf_wr[j] = digit_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        buf_nxt   = entry_buf;
        pswd_nxt  = pswd;
        idx_nxt   = idx;
        fail_nxt  = fail_cnt;
        err_nxt   = err_flag;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (enter) begin
                    buf_nxt = buf_wr;
                    err_nxt = 1'b0;
                    if (DIGITS == 1) begin
                        state_nxt = CHECK;
                    end else begin
                        idx_nxt   = 3'd1;
                        state_nxt = ENTRY;
                    end
                end else if (cancel) begin
                    err_nxt = 1'b0;
                end
            end
            ENTRY: begin
                if (cancel) begin
                    idx_nxt   = '0;
                    buf_nxt   = '0;
                    state_nxt = IDLE;
                end else if (enter) begin
                    buf_nxt = buf_wr;
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = CHECK;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            CHECK: begin
                if (entry_buf == pswd) begin
                    fail_nxt  = '0;
                    state_nxt = OPEN;
                end else if ((fail_cnt + 3'd1) == ALLOWED_3) begin
                    fail_nxt  = ALLOWED_3;
                    tmr_load  = 1'b1;
                    state_nxt = LOCKOUT;
                end else begin
                    fail_nxt  = fail_cnt + 3'd1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OPEN: begin
                if (close) begin
                    state_nxt = IDLE;
                end else if (confirm) begin
                    idx_nxt   = '0;
                    state_nxt = SET_ENTRY;
                end
            end
            SET_ENTRY: begin
                if (cancel) begin
                    idx_nxt   = '0;
                    state_nxt = OPEN;
                end else if (enter) begin
                    buf_nxt = buf_wr;
                    if (idx == LAST_IDX) begin
                        pswd_nxt  = buf_wr;
                        idx_nxt   = '0;
                        state_nxt = OPEN;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            LOCKOUT: begin
                // Timer was loaded with N-1, so N cycles elapse before release.
                if (tmr_zero) begin
                    fail_nxt  = '0;
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign locked     = (state == LOCKOUT);
    assign green_n    = ~((state == OPEN) || (state == SET_ENTRY));
    assign red_n      = ~(err_flag | locked);
    assign tries_left = ALLOWED_3 - fail_cnt;
    assign digit_idx  = idx;
    assign state_o    = state;

endmodule

// File: tb/tb_coffer_seq_ctrl.sv
// Bench for coffer_seq_ctrl: directed scenarios followed by random attempts,
// checked against a transaction-level model of the lock (stored code, failure count, open flag).
module tb_coffer_seq_ctrl;

    localparam int DIGITS  = 4;
    localparam int ALLOWED = 4;
    localparam int LCYC    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit_in = 4'h0;
    logic       enter = 1'b0, cancel = 1'b0, confirm = 1'b0, close = 1'b0;
    logic       green_n, red_n, locked;
    logic [2:0] tries_left, digit_idx, state_o;

    coffer_seq_ctrl #(
        .DIGITS         (DIGITS),
        .ALLOWED        (ALLOWED),
        .LOCKOUT_CYCLES (LCYC),
        .DEFAULT_PSWD   (16'h0007)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_in   (digit_in),
        .enter      (enter),
        .cancel     (cancel),
        .confirm    (confirm),
        .close      (close),
        .green_n    (green_n),
        .red_n      (red_n),
        .locked     (locked),
        .tries_left (tries_left),
        .digit_idx  (digit_idx),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] m_pswd;
    int          m_fails;
    bit          m_open;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called 1ns after a rising edge; drives for one cycle and returns 1ns after the next edge.
    task automatic cyc(input bit en, input bit ca, input bit cf, input bit cl, input logic [3:0] d);
        enter = en; cancel = ca; confirm = cf; close = cl; digit_in = d;
        @(posedge clk); #1;
        enter = 1'b0; cancel = 1'b0; confirm = 1'b0; close = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_green"}, 32'(green_n), 32'd1);
        chk({tag, "_red"},   32'(red_n),   32'd1);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_tries"}, 32'(tries_left), 32'(ALLOWED));
        chk({tag, "_idx"},   32'(digit_idx), 32'd0);
    endtask

    // Lockout lasts LCYC cycles from the edge that entered it; junk inputs must be ignored.
    task automatic lockout_wait();
        for (int k = 0; k < LCYC - 1; k++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            chk("lock_hold_state", 32'(state_o), 32'd5);
            chk("lock_hold_idx", 32'(digit_idx), 32'd0);
        end
        cyc(0, 0, 0, 0, 4'h0);
        chk("lock_exit_state", 32'(state_o), 32'd0);
        chk("lock_exit_tries", 32'(tries_left), 32'(ALLOWED));
        chk("lock_exit_red", 32'(red_n), 32'd1);
        m_fails = 0;
    endtask

    task automatic try_code(input logic [15:0] code);
        for (int i = 0; i < DIGITS; i++) begin
            cyc(1, 0, 0, 0, code[15 - 4*i -: 4]);
            if (i < DIGITS - 1) chk("entry_idx", 32'(digit_idx), 32'(i + 1));
        end
        chk("in_check", 32'(state_o), 32'd2);
        chk("check_idx", 32'(digit_idx), 32'd0);
        cyc(0, 0, 0, 0, 4'h0);
        if (code == m_pswd) begin
            m_fails = 0;
            m_open  = 1'b1;
            chk("open_green", 32'(green_n), 32'd0);
            chk("open_state", 32'(state_o), 32'd3);
            chk("open_tries", 32'(tries_left), 32'(ALLOWED));
        end else begin
            m_fails++;
            if (m_fails == ALLOWED) begin
                chk("lock_locked", 32'(locked), 32'd1);
                chk("lock_red", 32'(red_n), 32'd0);
                chk("lock_tries", 32'(tries_left), 32'd0);
                lockout_wait();
            end else begin
                chk("bad_red", 32'(red_n), 32'd0);
                chk("bad_green", 32'(green_n), 32'd1);
                chk("bad_state", 32'(state_o), 32'd0);
                chk("bad_tries", 32'(tries_left), 32'(ALLOWED - m_fails));
            end
        end
    endtask

    task automatic close_it();
        cyc(0, 0, 0, 1, 4'h0);
        chk("close_state", 32'(state_o), 32'd0);
        chk("close_green", 32'(green_n), 32'd1);
        m_open = 1'b0;
    endtask

    task automatic program_code(input logic [15:0] code);
        cyc(0, 0, 1, 0, 4'h0);
        chk("set_state", 32'(state_o), 32'd4);
        chk("set_green", 32'(green_n), 32'd0);
        for (int i = 0; i < DIGITS; i++) cyc(1, 0, 0, 0, code[15 - 4*i -: 4]);
        chk("set_done_state", 32'(state_o), 32'd3);
        m_pswd = code;
    endtask

    task automatic program_cancel(input int n);
        cyc(0, 0, 1, 0, 4'h0);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 4'($urandom_range(0, 15)));
        cyc(0, 1, 0, 0, 4'h0);
        chk("setcan_state", 32'(state_o), 32'd3);
        chk("setcan_idx", 32'(digit_idx), 32'd0);
    endtask

    task automatic partial_cancel(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 4'($urandom_range(0, 15)));
        cyc(1, 1, 0, 0, 4'($urandom_range(0, 15)));
        chk("pcan_state", 32'(state_o), 32'd0);
        chk("pcan_idx", 32'(digit_idx), 32'd0);
        chk("pcan_tries", 32'(tries_left), 32'(ALLOWED - m_fails));
        chk("pcan_red", 32'(red_n), 32'd1);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b1;
        m_pswd = 16'h0007; m_fails = 0; m_open = 1'b0;

        // Default code opens; then three bad attempts and a fourth into lockout.
        try_code(16'h0007);
        close_it();
        repeat (4) try_code(16'h1234);

        // A cancel in IDLE clears the error indication but keeps the failure count.
        try_code(16'h1234);
        cyc(0, 1, 0, 0, 4'h0);
        chk("idle_cancel_red", 32'(red_n), 32'd1);
        chk("idle_cancel_tries", 32'(tries_left), 32'(ALLOWED - m_fails));

        // Re-program to ABCD; confirm+close together must close.
        try_code(16'h0007);
        program_code(16'hABCD);
        cyc(0, 0, 1, 1, 4'h0);
        chk("conf_close_state", 32'(state_o), 32'd0);
        m_open = 1'b0;
        try_code(16'h0007);
        try_code(16'hABCD);
        close_it();

        // enter+cancel in the same cycle discards the digit.
        cyc(1, 0, 0, 0, 4'h0);
        cyc(1, 0, 0, 0, 4'h0);
        chk("pre_cancel_idx", 32'(digit_idx), 32'd2);
        partial_cancel(0);
        try_code(m_pswd);
        close_it();

        // Asynchronous reset mid-programming restores the default code.
        try_code(m_pswd);
        cyc(0, 0, 1, 0, 4'h0);
        cyc(1, 0, 0, 0, 4'h5);
        cyc(1, 0, 0, 0, 4'h6);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("rst_set");
        @(posedge clk); #1;
        reset = 1'b1;
        m_pswd = 16'h0007; m_fails = 0; m_open = 1'b0;
        try_code(16'h0007);
        close_it();

        // Asynchronous reset mid-lockout.
        repeat (ALLOWED - 1) try_code(16'h4321);
        for (int i = 0; i < DIGITS; i++) cyc(1, 0, 0, 0, 4'h9);
        cyc(0, 0, 0, 0, 4'h0);
        chk("rst_lock_pre", 32'(locked), 32'd1);
        cyc(1, 0, 1, 1, 4'h0);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("rst_lock");
        @(posedge clk); #1;
        reset = 1'b1;
        m_fails = 0;

        for (int it = 0; it < 40; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (m_open) begin
                if (r < 4) program_code(16'($urandom_range(0, 65535)));
                else if (r < 6) program_cancel(int'($urandom_range(0, 3)));
                else close_it();
            end else begin
                if (r < 3) try_code(m_pswd);
                else if (r < 8) try_code(16'($urandom_range(0, 65535)));
                else partial_cancel(int'($urandom_range(1, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
